// File: rtl/prs_pkg.sv
// -----------------------------------------------------------------------------
// prs_pkg
// Shared constants for the parametrised ring/shift register family:
//   - mode encodings applied to the 2-bit mode select
//   - shift direction encodings
// -----------------------------------------------------------------------------
package prs_pkg;

    localparam logic [1:0] MODE_HOLD    = 2'b00;
    localparam logic [1:0] MODE_SHIFT   = 2'b01;
    localparam logic [1:0] MODE_RING    = 2'b10;
    localparam logic [1:0] MODE_JOHNSON = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage : prs_pkg

// File: rtl/step_period_counter.sv
// -----------------------------------------------------------------------------
// step_period_counter
// Counts executed steps of a sequencer and emits a one-cycle registered pulse
// on the step that completes a period.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (count=0, wrap=0)
//   clr    in   discard the current count; a step in the same cycle counts as 1
//   step   in   an executed step happens this cycle
//   period in   period length in steps (must be >= 2)
//   wrap   out  registered pulse, high after the step that completes the period
// -----------------------------------------------------------------------------
module step_period_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             step,
    input  logic [CNT_W:0]   period,
    output logic             wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;
    logic [CNT_W-1:0] w_base;
    logic             w_last;

    // Count the step on top of a cleared value when clr is asserted alongside it.
    always_comb begin
        w_base = {CNT_W{1'b0}};
        if (clr) begin
            w_base = {CNT_W{1'b0}};
        end else begin
            w_base = r_cnt;
        end
        w_last = ({1'b0, w_base} == (period - {{CNT_W{1'b0}}, 1'b1}));
    end

    // Step counter and period-complete pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_wrap <= 1'b0;
        end else if (step) begin
            if (w_last) begin
                r_cnt  <= {CNT_W{1'b0}};
                r_wrap <= 1'b1;
            end else begin
                r_cnt  <= w_base + {{(CNT_W-1){1'b0}}, 1'b1};
                r_wrap <= 1'b0;
            end
        end else begin
            r_cnt  <= w_base;
            r_wrap <= 1'b0;
        end
    end

    assign wrap = r_wrap;

endmodule : step_period_counter

// File: rtl/param_ring_shift_reg.sv
// -----------------------------------------------------------------------------
// param_ring_shift_reg
// WIDTH-bit register with run-time mode: hold, serial shift, ring rotate and
// Johnson (twisted ring), plus direction control, parallel load, ring
// self-start from all-zero and a registered period-complete pulse.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   en       in   step enable
//   mode     in   00 HOLD, 01 SHIFT, 10 RING, 11 JOHNSON
//   dir      in   0 right (toward LSB), 1 left (toward MSB)
//   ser_in   in   serial input bit (SHIFT mode)
//   load     in   parallel load strobe (overrides en/mode)
//   par_in   in   parallel load value
//   out      out  register contents
//   ser_out  out  bit leaving the register in the current direction
//   wrap     out  one-cycle pulse when a full period completes
// -----------------------------------------------------------------------------
module param_ring_shift_reg
    import prs_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             ser_in,
    input  logic             load,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] out,
    output logic             ser_out,
    output logic             wrap
);

    localparam int               CNT_W    = $clog2(2 * WIDTH);
    localparam logic [CNT_W:0]   PER_NORM = (CNT_W + 1)'(WIDTH);
    localparam logic [CNT_W:0]   PER_JOHN = (CNT_W + 1)'(2 * WIDTH);

    logic [WIDTH-1:0] r_out;
    logic [1:0]       r_mode_q;
    logic             w_ser_out;
    logic             w_feed;
    logic             w_self_start;
    logic             w_step;
    logic             w_clr;
    logic [CNT_W:0]   w_period;
    logic [WIDTH-1:0] w_next;

    // Feed bit, step qualification and shifted value.
    always_comb begin
        w_ser_out = (dir == DIR_LEFT) ? r_out[WIDTH-1] : r_out[0];
        case (mode)
            MODE_SHIFT:   w_feed = ser_in;
            MODE_RING:    w_feed = w_ser_out;
            MODE_JOHNSON: w_feed = ~w_ser_out;
            default:      w_feed = 1'b0;
        endcase
        // An all-zero ring would rotate zeros forever; inject SEED instead.
        w_self_start = en && (mode == MODE_RING) && (r_out == {WIDTH{1'b0}});
        w_step       = !load && en && (mode != MODE_HOLD) && !w_self_start;
        // Any re-seeding of the register or a mode switch restarts the period.
        w_clr        = load || w_self_start || (mode != r_mode_q);
        w_period     = (mode == MODE_JOHNSON) ? PER_JOHN : PER_NORM;
        if (dir == DIR_LEFT) begin
            w_next = {r_out[WIDTH-2:0], w_feed};
        end else begin
            w_next = {w_feed, r_out[WIDTH-1:1]};
        end
    end

    // Register contents: reset > load > self-start > step > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= {WIDTH{1'b0}};
        end else if (load) begin
            r_out <= par_in;
        end else if (w_self_start) begin
            r_out <= SEED;
        end else if (w_step) begin
            r_out <= w_next;
        end else begin
            r_out <= r_out;
        end
    end

    // Previous-cycle mode, used to detect a mode switch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_q <= MODE_HOLD;
        end else begin
            r_mode_q <= mode;
        end
    end

    step_period_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_clr),
        .step   (w_step),
        .period (w_period),
        .wrap   (wrap)
    );

    assign out     = r_out;
    assign ser_out = w_ser_out;

endmodule : param_ring_shift_reg

// File: tb/tb_param_ring_shift_reg.sv
module tb_param_ring_shift_reg;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         dir = 1'b0;
    logic         ser_in = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] par_in = 4'b0000;
    logic [W-1:0] out;
    logic         ser_out;
    logic         wrap;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] m_out    = 4'b0000;
    int           m_cnt    = 0;
    logic         m_wrap   = 1'b0;
    logic [1:0]   m_mode_q = 2'b00;

    always #5 clk = ~clk;

    param_ring_shift_reg #(.WIDTH(W), .SEED(4'b0001)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
        .ser_in(ser_in), .load(load), .par_in(par_in),
        .out(out), .ser_out(ser_out), .wrap(wrap)
    );

    function automatic void model_step();
        logic f;
        logic so;
        logic chg;
        int   per;
        int   v;
        if (reset) begin
            m_out = 4'b0000; m_cnt = 0; m_wrap = 1'b0; m_mode_q = 2'b00;
        end else begin
            chg      = (mode != m_mode_q);
            m_mode_q = mode;
            so  = ((int'(m_out) >> (dir ? (W - 1) : 0)) % 2) == 1;
            per = (mode == 2'b11) ? 2 * W : W;
            f   = (mode == 2'b01) ? ser_in : ((mode == 2'b10) ? so : !so);
            if (load) begin
                m_out = par_in; m_cnt = 0; m_wrap = 1'b0;
            end else if (en && mode == 2'b10 && m_out == 4'b0000) begin
                m_out = 4'b0001; m_cnt = 0; m_wrap = 1'b0;
            end else if (en && mode != 2'b00) begin
                if (chg) m_cnt = 0;
                v = int'(m_out);
                if (dir) v = (v * 2 + int'(f)) % (1 << W);
                else     v = v / 2 + (f ? (1 << (W - 1)) : 0);
                m_out = W'(v);
                m_cnt = m_cnt + 1;
                if (m_cnt == per) begin
                    m_cnt = 0; m_wrap = 1'b1;
                end else begin
                    m_wrap = 1'b0;
                end
            end else begin
                if (chg) m_cnt = 0;
                m_wrap = 1'b0;
            end
        end
    endfunction

    // one clock edge with the currently driven inputs, then check against the model
    task automatic cyc();
        logic e_so;
        model_step();
        @(posedge clk);
        #1;
        e_so = ((int'(m_out) >> (dir ? (W - 1) : 0)) % 2) == 1;
        total++;
        assert (out === m_out) else begin
            bad++; $error("FAIL model_out observed=%b expected=%b", out, m_out);
        end
        total++;
        assert (wrap === m_wrap) else begin
            bad++; $error("FAIL model_wrap observed=%b expected=%b", wrap, m_wrap);
        end
        total++;
        assert (ser_out === e_so) else begin
            bad++; $error("FAIL model_ser_out observed=%b expected=%b", ser_out, e_so);
        end
    endtask

    task automatic expect_c(input string tag, input logic [W-1:0] e_out, input logic e_wrap);
        total++;
        assert (out === e_out) else begin
            bad++; $error("FAIL %s out observed=%b expected=%b", tag, out, e_out);
        end
        total++;
        assert (wrap === e_wrap) else begin
            bad++; $error("FAIL %s wrap observed=%b expected=%b", tag, wrap, e_wrap);
        end
    endtask

    task automatic expect_so(input string tag, input logic e_so);
        total++;
        assert (ser_out === e_so) else begin
            bad++; $error("FAIL %s ser_out observed=%b expected=%b", tag, ser_out, e_so);
        end
    endtask

    logic [W-1:0] exp_ring [6] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [W-1:0] exp_load [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
    logic         so_load  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] exp_john [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                   4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic         sin_seq  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] exp_shift[4] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};

    initial begin
        // reset
        @(negedge clk);
        reset = 1'b1; cyc(); expect_c("reset", 4'b0000, 1'b0);
        reset = 1'b0;

        // ring with self-start
        mode = 2'b10; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(); expect_c("ring_selfstart", exp_ring[i], (i == 4));
        end

        // load then ring rotate
        load = 1'b1; par_in = 4'b1001; cyc(); load = 1'b0;
        expect_c("load_1001", 4'b1001, 1'b0); expect_so("load_1001", 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(); expect_c("ring_after_load", exp_load[i], (i == 3));
            expect_so("ring_after_load", so_load[i]);
        end

        // johnson left from reset
        reset = 1'b1; cyc(); reset = 1'b0;
        mode = 2'b11; dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(); expect_c("johnson_left", exp_john[i], (i == 7));
        end

        // serial shift right from reset, then hold
        reset = 1'b1; cyc(); reset = 1'b0;
        mode = 2'b01; dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ser_in = sin_seq[i];
            cyc(); expect_c("shift_right", exp_shift[i], (i == 3));
        end
        en = 1'b0; cyc(); expect_c("hold_en0", 4'b1101, 1'b0);
        cyc(); expect_c("hold_en0", 4'b1101, 1'b0);
        en = 1'b1; mode = 2'b00; cyc(); expect_c("hold_mode", 4'b1101, 1'b0);

        // load beats enable, then mode switch restarts the period
        load = 1'b1; mode = 2'b10; par_in = 4'b0110; cyc(); load = 1'b0;
        expect_c("load_wins", 4'b0110, 1'b0);
        cyc(); expect_c("ring_step1", 4'b0011, 1'b0);
        cyc(); expect_c("ring_step2", 4'b1001, 1'b0);
        mode = 2'b11;
        for (int i = 0; i < 8; i++) begin
            cyc();
            total++;
            assert (wrap === (i == 7)) else begin
                bad++; $error("FAIL mode_switch_wrap observed=%b expected=%b", wrap, (i == 7));
            end
        end

        // reset beats load, then ring self-starts again
        mode = 2'b10; cyc(); cyc();
        reset = 1'b1; load = 1'b1; par_in = 4'b1111; cyc();
        expect_c("reset_over_load", 4'b0000, 1'b0);
        reset = 1'b0; load = 1'b0; cyc(); expect_c("selfstart_again", 4'b0001, 1'b0);

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 39) == 0);
            load   = ($urandom_range(0, 7) == 0);
            en     = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) dir = ~dir;
            ser_in = 1'($urandom_range(0, 1));
            par_in = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_param_ring_shift_reg
